// File: rtl/dram_cache_pkg.sv
// Shared types and geometry for the direct-mapped, write-through DRAM cache.
package dram_cache_pkg;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = 19;
  localparam int LINES   = 64;
  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    RD_MISS = 2'd2,
    WR_THRU = 2'd3
  } state_t;
endpackage

// File: rtl/dram_cache.sv
// Direct-mapped, write-through, write-allocate cache: 64 one-word lines in front of DRAM.
// Optional DRAM_CACHE_STATS_EN adds saturating read hit/miss counters.
module dram_cache
  import dram_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              c_valid,
  input  logic              c_rw,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_din,
  input  logic              c_flush,
  output logic [DATA_W-1:0] c_dout,
  output logic              c_ready,
  output logic [ADDR_W-1:0] addr_dram,
  output logic [DATA_W-1:0] din_dram,
  output logic              rw_dram,
  output logic              valid_dram,
  input  logic [DATA_W-1:0] dout_dram,
  input  logic              ready_dram
`ifdef DRAM_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  state_t              state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rw;
  logic [DATA_W-1:0]   r_din;
  logic [DATA_W-1:0]   data_mem [LINES];
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [LINES-1:0]    vld;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                fill;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^c_addr[1:0];
  assign idx  = r_addr[INDEX_W+1:2];
  assign tag  = r_addr[ADDR_W-1:INDEX_W+2];
  assign hit  = vld[idx] && (tag_mem[idx] == tag);
  // Completion of an outstanding DRAM access allocates the line (both reads and writes).
  assign fill = rstn && valid_dram && ready_dram && ((state == RD_MISS) || (state == WR_THRU));

  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[idx] <= (state == RD_MISS) ? dout_dram : r_din;
      tag_mem[idx]  <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      vld        <= '0;
      c_ready    <= 1'b0;
      c_dout     <= '0;
      valid_dram <= 1'b0;
      rw_dram    <= 1'b0;
      addr_dram  <= '0;
      din_dram   <= '0;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_din      <= '0;
    end else begin
      c_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (c_flush) begin
            vld <= '0;
          end else if (c_valid) begin
            r_addr <= c_addr;
            r_rw   <= c_rw;
            r_din  <= c_din;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          addr_dram <= {r_addr[ADDR_W-1:2], 2'b00};
          din_dram  <= r_din;
          rw_dram   <= r_rw;
          if (r_rw) begin
            valid_dram <= 1'b1;
            state      <= WR_THRU;
          end else if (hit) begin
            c_ready <= 1'b1;
            c_dout  <= data_mem[idx];
            state   <= IDLE;
          end else begin
            valid_dram <= 1'b1;
            state      <= RD_MISS;
          end
        end
        RD_MISS, WR_THRU: begin
          if (valid_dram && ready_dram) begin
            valid_dram <= 1'b0;
            c_ready    <= 1'b1;
            vld[idx]   <= 1'b1;
            if (state == RD_MISS) c_dout <= dout_dram;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRAM_CACHE_STATS_EN
  logic lookup_rd;
  assign lookup_rd = (state == LOOKUP) && !r_rw;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (lookup_rd) begin
      if (hit && (hit_cnt != 32'hFFFF_FFFF))   hit_cnt  <= hit_cnt + 32'd1;
      if (!hit && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_cache.sv
// Scoreboard bench for dram_cache: directed requests, DRAM responder model, decoupled core monitor.
module tb_dram_cache;
  logic        clk, rstn;
  logic        c_valid, c_rw, c_flush;
  logic [26:0] c_addr;
  logic [31:0] c_din, c_dout;
  logic        c_ready;
  logic [26:0] addr_dram;
  logic [31:0] din_dram, dout_dram;
  logic        rw_dram, valid_dram, ready_dram;
`ifdef DRAM_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dram_cache dut (
    .clk(clk), .rstn(rstn), .c_valid(c_valid), .c_rw(c_rw), .c_addr(c_addr),
    .c_din(c_din), .c_flush(c_flush), .c_dout(c_dout), .c_ready(c_ready),
    .addr_dram(addr_dram), .din_dram(din_dram), .rw_dram(rw_dram),
    .valid_dram(valid_dram), .dout_dram(dout_dram), .ready_dram(ready_dram)
`ifdef DRAM_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  typedef struct {
    logic        rd;
    logic [31:0] data;
  } core_exp_t;

  typedef struct {
    logic        rw;
    logic [26:0] addr;
    logic [31:0] din;
    logic [31:0] rdata;
    int          delay;
  } dram_exp_t;

  core_exp_t core_q[$];
  dram_exp_t dram_q[$];
  core_exp_t ce;
  dram_exp_t de;
  bit        aborted;
  int        pass_cnt = 0;
  int        chk_cnt  = 0;
  int        dram_cnt = 0;
  int        lat, nd, cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Core-side monitor: every c_ready pulse consumes one expected response.
  always @(negedge clk) begin
    if (c_ready) begin
      if (core_q.size() == 0) check("core_unexpected_ready", 32'(c_ready), 32'd0);
      else begin
        ce = core_q.pop_front();
        if (ce.rd) check("core_rdata", c_dout, ce.data);
      end
    end
  end

  // DRAM model: checks each request, holds it for the programmed delay, then pulses ready.
  initial begin
    ready_dram = 1'b0;
    dout_dram  = '0;
    forever begin
      @(negedge clk);
      if (rstn && valid_dram) begin
        dram_cnt++;
        if (dram_q.size() == 0) check("dram_unexpected", 32'(valid_dram), 32'd0);
        else begin
          de = dram_q.pop_front();
          check("dram_addr", 32'(addr_dram), 32'(de.addr));
          check("dram_rw", 32'(rw_dram), 32'(de.rw));
          if (de.rw) check("dram_din", din_dram, de.din);
          aborted = 1'b0;
          for (int i = 0; i < de.delay; i++) begin
            @(negedge clk);
            if (!rstn) begin
              aborted = 1'b1;
              break;
            end
            check("dram_hold_valid", 32'(valid_dram), 32'd1);
            check("dram_hold_addr", 32'(addr_dram), 32'(de.addr));
          end
          if (!aborted) begin
            ready_dram = 1'b1;
            dout_dram  = de.rdata;
            @(negedge clk);
            ready_dram = 1'b0;
          end
        end
      end
    end
  end

  task automatic req(input logic rw, input logic [26:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input bit miss, input int delay,
                     output int l, output int n);
    int base;
    base = dram_cnt;
    core_q.push_back('{rd: !rw, data: exp});
    if (miss) dram_q.push_back('{rw: rw, addr: {a[26:2], 2'b00}, din: d, rdata: exp, delay: delay});
    c_valid = 1'b1; c_rw = rw; c_addr = a; c_din = d;
    l = 0;
    while (!c_ready && l < 300) begin
      @(posedge clk); #1;
      l++;
    end
    c_valid = 1'b0;
    check("req_complete", 32'(c_ready), 32'd1);
    @(posedge clk); #1;
    n = dram_cnt - base;
    check("resp_drained", 32'(core_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", chk_cnt);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; c_valid = 1'b0; c_rw = 1'b0; c_addr = '0; c_din = '0; c_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_c_ready", 32'(c_ready), 32'd0);
    check("rst_valid_dram", 32'(valid_dram), 32'd0);
    check("rst_rw_dram", 32'(rw_dram), 32'd0);
    check("rst_addr_dram", 32'(addr_dram), 32'd0);
    check("rst_din_dram", din_dram, 32'd0);
    check("rst_c_dout", c_dout, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // cold read miss, then hit
    req(1'b0, 27'h0, 32'h0, 32'h0f0f0f0f, 1'b1, 3, lat, nd);
    check("cold_miss_dram_cnt", 32'(nd), 32'd1);
    req(1'b0, 27'h0, 32'h0, 32'h0f0f0f0f, 1'b0, 0, lat, nd);
    check("hit_latency", 32'(lat), 32'd2);
    check("hit_dram_cnt", 32'(nd), 32'd0);

    // write-through allocates, read hits
    req(1'b1, 27'h4, 32'h1e1e1e1e, 32'h0, 1'b1, 2, lat, nd);
    check("wr_dram_cnt", 32'(nd), 32'd1);
    req(1'b0, 27'h4, 32'h0, 32'h1e1e1e1e, 1'b0, 0, lat, nd);
    check("wr_alloc_hit_latency", 32'(lat), 32'd2);
    check("wr_alloc_hit_dram_cnt", 32'(nd), 32'd0);

    // conflict on index 0 evicts 0x0
    req(1'b0, 27'h100, 32'h0, 32'h55aa55aa, 1'b1, 1, lat, nd);
    check("conflict_miss_dram_cnt", 32'(nd), 32'd1);
    req(1'b0, 27'h0, 32'h0, 32'h0f0f0f0f, 1'b1, 4, lat, nd);
    check("evicted_miss_dram_cnt", 32'(nd), 32'd1);
    req(1'b0, 27'h7, 32'h0, 32'h1e1e1e1e, 1'b0, 0, lat, nd);
    check("other_index_hit_dram_cnt", 32'(nd), 32'd0);

    // flush, then long DRAM stall
    c_flush = 1'b1;
    @(posedge clk); #1;
    c_flush = 1'b0;
    req(1'b0, 27'h4, 32'h0, 32'h1e1e1e1e, 1'b1, 50, lat, nd);
    check("flush_miss_dram_cnt", 32'(nd), 32'd1);

    // reset while a read miss is outstanding
    dram_q.push_back('{rw: 1'b0, addr: 27'h8, din: 32'h0, rdata: 32'hdeadbeef, delay: 20});
    c_valid = 1'b1; c_rw = 1'b0; c_addr = 27'h8;
    cyc = 0;
    while (!valid_dram && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_miss_issued", 32'(valid_dram), 32'd1);
    c_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check("abort_valid_dram", 32'(valid_dram), 32'd0);
    check("abort_c_ready", 32'(c_ready), 32'd0);
    rstn = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort_dram_q", 32'(dram_q.size()), 32'd0);
    req(1'b0, 27'h8, 32'h0, 32'h3c3c3c3c, 1'b1, 2, lat, nd);
    check("post_abort_miss_dram_cnt", 32'(nd), 32'd1);

`ifdef DRAM_CACHE_STATS_EN
    check("stats_hit_cnt", hit_cnt, 32'd0);
    check("stats_miss_cnt", miss_cnt, 32'd1);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
